// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus the writeback datapath.
// Captures the memory-stage bundle, aligns and extends load data, picks the
// final result, drives the register-file write port, flags misaligned loads
// and counts retired instructions.
module writeback_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             valid_m,
   input  logic             reg_write_m,
   input  logic [1:0]       result_src_m,
   input  logic [4:0]       rd_m,
   input  logic [2:0]       funct3_m,
   input  logic [XLEN-1:0]  alu_result_m,
   input  logic [XLEN-1:0]  read_data_m,
   input  logic [XLEN-1:0]  pc_plus4_m,
   input  logic             stall_w,
   input  logic             flush_w,
   output logic             valid_w,
   output logic             reg_write_w,
   output logic [4:0]       rd_w,
   output logic [XLEN-1:0]  result_w,
   output logic             load_misalign_w,
   output logic [CNT_W-1:0] instret
);

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;

   // MEM/WB register fields
   logic            valid_r;
   logic            reg_write_r;
   logic [1:0]      result_src_r;
   logic [4:0]      rd_r;
   logic [2:0]      funct3_r;
   logic [XLEN-1:0] alu_result_r;
   logic [XLEN-1:0] read_data_r;
   logic [XLEN-1:0] pc_plus4_r;

   logic [1:0]      ofs;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_value;

   // MEM/WB register: flush squashes (and wins over stall), stall holds, else capture
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         valid_r      <= 1'b0;
         reg_write_r  <= 1'b0;
         result_src_r <= SRC_ALU;
         rd_r         <= '0;
         funct3_r     <= '0;
         alu_result_r <= '0;
         read_data_r  <= '0;
         pc_plus4_r   <= '0;
      end else if (flush_w) begin
         valid_r      <= 1'b0;
         reg_write_r  <= 1'b0;
         result_src_r <= SRC_ALU;
         rd_r         <= '0;
         funct3_r     <= '0;
         alu_result_r <= '0;
         read_data_r  <= '0;
         pc_plus4_r   <= '0;
      end else if (!stall_w) begin
         valid_r      <= valid_m;
         reg_write_r  <= reg_write_m;
         result_src_r <= result_src_m;
         rd_r         <= rd_m;
         funct3_r     <= funct3_m;
         alu_result_r <= alu_result_m;
         read_data_r  <= read_data_m;
         pc_plus4_r   <= pc_plus4_m;
      end
   end

   // Retired-instruction counter: the WB instruction retires when it leaves (not stalled)
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         instret <= '0;
      end else if (valid_r && !stall_w) begin
         instret <= instret + 1'b1;
      end
   end

   assign ofs = alu_result_r[1:0];

   // Little-endian byte/halfword selection and sign/zero extension of the load word
   // NOTE: every output gets a default first so no path through the block
   // leaves a value unassigned and infers a latch.
   always_comb begin
      load_byte  = read_data_r[8*ofs +: 8];
      load_half  = ofs[1] ? read_data_r[31:16] : read_data_r[15:0];
      load_value = read_data_r;
      case (funct3_r)
         3'b000:  load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
         3'b100:  load_value = {{(XLEN-8){1'b0}}, load_byte};
         3'b001:  load_value = {{(XLEN-16){load_half[15]}}, load_half};
         3'b101:  load_value = {{(XLEN-16){1'b0}}, load_half};
         default: load_value = read_data_r;
      endcase
   end

   // Misaligned halfword (odd offset) or word (nonzero offset) load in WB
   always_comb begin
      load_misalign_w = valid_r && (result_src_r == SRC_LOAD) &&
                        (((funct3_r[1:0] == 2'b01) && ofs[0]) ||
                         ((funct3_r[1:0] == 2'b10) && (ofs != 2'b00)));
   end

   // Final result select; the reserved source code falls back to the ALU result
   always_comb begin
      case (result_src_r)
         SRC_LOAD: result_w = load_value;
         SRC_PC4:  result_w = pc_plus4_r;
         default:  result_w = alu_result_r;
      endcase
   end

   // Register-file write port: x0 and misaligned loads never write
   always_comb begin
      valid_w     = valid_r;
      rd_w        = rd_r;
      reg_write_w = valid_r && reg_write_r && (rd_r != 5'd0) && !load_misalign_w;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus the writeback datapath of the 5-stage RV32I core.
- Captures the memory-stage bundle each cycle and aligns and sign-extends load data.
- Selects the final result and drives the register-file write port of the decode stage (reg_write_w, rd_w, result_w).
- Also flags misaligned loads and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- srst  in  1  asynchronous reset, active-high
- valid_m  in  1  memory-stage slot holds a real instruction
- reg_write_m  in  1  instruction writes rd
- result_src_m  in  2  00 ALU, 01 load data, 10 pc+4, 11 reserved (treated as ALU)
- rd_m  in  5  destination register index
- funct3_m  in  3  load size/sign code
- alu_result_m  in  XLEN  ALU result / load byte address
- read_data_m  in  XLEN  raw 32-bit word from data memory
- pc_plus4_m  in  XLEN  link value
- stall_w  in  1  hold MEM/WB register
- flush_w  in  1  squash instruction entering MEM/WB
- valid_w  out  1  WB slot valid
- reg_write_w  out  1  register-file write enable to decode stage
- rd_w  out  5  register-file write address
- result_w  out  XLEN  register-file write data
- load_misalign_w  out  1  WB instruction is a misaligned load
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, on srst high; released synchronously to clk):
  - valid_w=0, reg_write_w=0, rd_w=0, result_w=0, load_misalign_w=0, instret=0.
  - All MEM/WB fields are zero.
- MEM/WB register update on rising clk, by priority:
  - flush_w=1: valid and reg_write fields cleared; data fields don't-care (tests expect 0).
  - else stall_w=1: all fields hold.
  - else capture all *_m inputs.
- Flush wins over simultaneous stall.
- Latency: an instruction presented on *_m appears on *_w outputs one cycle later.
- WB outputs are combinational from registered fields only; there is no path from *_m to *_w.
- Load extraction (ofs = registered alu_result[1:0]):
  - funct3 000 LB: sign-extend byte ofs.
  - funct3 100 LBU: zero-extend byte ofs.
  - funct3 001 LH: sign-extend halfword ofs[1].
  - funct3 101 LHU: zero-extend halfword ofs[1].
  - funct3 010 LW: full word.
  - funct3 011/110/111: full word.
  - Little-endian: byte 0 = bits[7:0].
- Misalign:
  - load_misalign_w = valid & result_src==01 & ((funct3[1:0]==01 & ofs[0]) | (funct3[1:0]==10 & ofs!=0)).
- Result mux:
  - result_w = load value when result_src==01.
  - result_w = pc+4 when result_src==10.
  - result_w = ALU result otherwise.
- Write enable:
  - reg_write_w = valid & reg_write & (rd!=0) & !load_misalign_w.
  - rd_w = registered rd, passed through unchanged.
- While stalled, the WB instruction re-asserts the same write each cycle (idempotent, permitted).
- instret:
  - Increments by 1 on each rising edge where valid_w=1 and stall_w=0.
  - Counts regardless of flush_w (flush affects only the incoming instruction).
  - Misaligned loads still retire and are counted.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-stall or mid-flush: reset dominates; state goes to reset values immediately.

Test Plan:
1. Reset, then ALU op with rd_m=5, alu_result_m=0x0000_1234, result_src_m=00, reg_write_m=1, valid_m=1 -> next cycle reg_write_w=1, rd_w=5, result_w=0x0000_1234, valid_w=1; instret=1 one edge later.
2. read_data_m=0x80FF_7F01:
   - LB, ofs=3 -> result_w=0xFFFF_FF80.
   - LBU, ofs=3 -> 0x0000_0080.
   - LH, ofs=2 -> 0xFFFF_80FF.
   - LHU, ofs=0 -> 0x0000_7F01.
   - LW -> 0x80FF_7F01.
3. LW with alu_result_m=0x102 -> load_misalign_w=1, reg_write_w=0, valid_w=1, instret still increments.
4. JAL: result_src_m=10, pc_plus4_m=0x44, rd_m=1 -> result_w=0x44, reg_write_w=1.
   - Same bundle with rd_m=0 -> reg_write_w=0.
5. Stall then flush:
   - Hold stall_w=1 for 3 cycles with new *_m values -> *_w unchanged, instret frozen.
   - Assert stall_w=1 and flush_w=1 together -> next cycle valid_w=0, reg_write_w=0.
6. Preload instret to 2^64-1 (or CNT_W=4, count 15), retire one instruction -> instret=0.
   - Assert srst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
